// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph code type, segment constants and code-to-segment helpers
package seg_pkg;

    typedef logic [3:0] glyph_code_t;

    // Active-low {P,G,F,E,D,C,B,A}
    localparam logic [7:0] SEG_C      = 8'hC6;
    localparam logic [7:0] SEG_D      = 8'hC0;
    localparam logic [7:0] SEG_E      = 8'h86;
    localparam logic [7:0] SEG_F      = 8'h8E;
    localparam logic [7:0] SEG_G      = 8'h82;
    localparam logic [7:0] SEG_A      = 8'h88;
    localparam logic [7:0] SEG_B      = 8'h80;
    localparam logic [7:0] SEG_HIGH_C = 8'h46;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    localparam glyph_code_t GLYPH_BLANK = 4'hF;

    function automatic logic [7:0] glyph_to_seg(input glyph_code_t code);
        logic [7:0] seg_v;
        case (code)
            4'd0:    seg_v = SEG_C;
            4'd1:    seg_v = SEG_D;
            4'd2:    seg_v = SEG_E;
            4'd3:    seg_v = SEG_F;
            4'd4:    seg_v = SEG_G;
            4'd5:    seg_v = SEG_A;
            4'd6:    seg_v = SEG_B;
            4'd7:    seg_v = SEG_HIGH_C;
            default: seg_v = SEG_BLANK;
        endcase
        return seg_v;
    endfunction

    function automatic logic glyph_is_blank(input glyph_code_t code);
        return code[3];
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - combinational decode of one glyph code to active-low segments
module seg_glyph_rom
    import seg_pkg::*;
(
    input  glyph_code_t code_i,
    output logic [7:0]  seg_o
);

    assign seg_o = glyph_to_seg(code_i);

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scanner with frame-atomic updates
// Optional digit blinking is built in when SEG_BLINK_EN is defined.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    load,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_pending,
    output logic                    frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [4*NUM_DIGITS-1:0] CODES_RST = {NUM_DIGITS{GLYPH_BLANK}};

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_codes_q, disp_codes_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_codes_q, pend_codes_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pending_q, pending_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic        tick;
    logic        wrap;
    glyph_code_t cur_code;
    logic [7:0]  rom_seg;
    logic [7:0]  seg_lit;
    logic        blink_off;

    assign tick     = (presc_q == PW'(REFRESH_DIV - 1));
    assign wrap     = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign cur_code = disp_codes_q[{idx_q, 2'b00} +: 4];

    seg_glyph_rom u_rom (
        .code_i (cur_code),
        .seg_o  (rom_seg)
    );

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Phase flips only at frame boundaries so a digit never blinks mid-frame.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (wrap) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_off = !blink_on_q && blink_mask[idx_q];
`else
    localparam int UNUSED_BLINK_DIV = BLINK_DIV;
    assign blink_off = 1'b0;
`endif

    always_comb begin
        seg_lit = rom_seg;
        if (disp_dp_q[idx_q] && !glyph_is_blank(cur_code)) begin
            seg_lit[7] = 1'b0;
        end
        if (blink_off) begin
            seg_lit = SEG_BLANK;
        end
    end

    // The output register latches the digit at idx_q while idx_q steps ahead.
    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        seg_d        = seg_q;
        an_d         = an_q;
        frame_d      = 1'b0;
        disp_codes_d = disp_codes_q;
        disp_dp_d    = disp_dp_q;
        pend_codes_d = pend_codes_q;
        pend_dp_d    = pend_dp_q;
        pending_d    = pending_q;
        if (tick) begin
            idx_d   = wrap ? '0 : idx_q + 1'b1;
            seg_d   = seg_lit;
            an_d    = ~(NUM_DIGITS'(1) << idx_q);
            frame_d = (idx_q == '0);
        end
        if (wrap && pending_q) begin
            disp_codes_d = pend_codes_q;
            disp_dp_d    = pend_dp_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            pend_codes_d = codes;
            pend_dp_d    = dp_mask;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_codes_q <= CODES_RST;
            disp_dp_q    <= '0;
            pend_codes_q <= CODES_RST;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_codes_q <= disp_codes_d;
            disp_dp_q    <= disp_dp_d;
            pend_codes_q <= pend_codes_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg            = seg_q;
    assign an             = an_q;
    assign update_pending = pending_q;
    assign frame_start    = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display with a frame-level reference model
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   codes = '0;
    logic [3:0]    dp_mask = '0;
    logic          load = 1'b0;
    logic [3:0]    blink_mask = 4'b0001;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          update_pending;
    logic          frame_start;

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .codes          (codes),
        .dp_mask        (dp_mask),
        .load           (load),
`ifdef SEG_BLINK_EN
        .blink_mask     (blink_mask),
`endif
        .seg            (seg),
        .an             (an),
        .update_pending (update_pending),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] seg;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Frame-level model: data visible in a frame is whatever was loaded before that frame's commit edge.
    int          m_edge;
    logic [15:0] m_disp_codes, m_pend_codes;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_flag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [7:0] ref_seg(input logic [3:0] c, input logic dp, input bit off);
        logic [7:0] s;
        case (c)
            4'd0: s = 8'hC6;
            4'd1: s = 8'hC0;
            4'd2: s = 8'h86;
            4'd3: s = 8'h8E;
            4'd4: s = 8'h82;
            4'd5: s = 8'h88;
            4'd6: s = 8'h80;
            4'd7: s = 8'h46;
            default: s = 8'hFF;
        endcase
        if (dp && c < 4'd8) s[7] = 1'b0;
        if (off) s = 8'hFF;
        return s;
    endfunction

    task automatic model_reset();
        m_edge       = 0;
        m_disp_codes = 16'hFFFF;
        m_pend_codes = 16'hFFFF;
        m_disp_dp    = '0;
        m_pend_dp    = '0;
        m_flag       = 1'b0;
    endtask

    // Called at a falling edge; drives the inputs seen by the next rising edge.
    task automatic step(input bit ld, input logic [15:0] c, input logic [3:0] dp);
        int   e, slot, d, f;
        bit   off;
        exp_t x;
        n_checks++;
        if (update_pending !== m_flag) begin
            n_fail++;
            $display("FAIL update_pending after edge %0d: got %b required %b", m_edge, update_pending, m_flag);
        end
        codes   = c;
        dp_mask = dp;
        load    = ld;
        e = m_edge + 1;
        if (e % RD == 0) begin
            slot = e / RD - 1;
            d    = slot % ND;
            f    = slot / ND;
            off  = 1'b0;
`ifdef SEG_BLINK_EN
            off  = blink_mask[d] && ((f / BD) % 2 == 1);
`endif
            x.e   = e;
            x.seg = ref_seg(m_disp_codes[4*d +: 4], m_disp_dp[d], off);
            x.an  = 4'hF;
            x.an[d] = 1'b0;
            x.fs  = (d == 0);
            sb.push_back(x);
        end
        if (e % (RD * ND) == 0 && m_flag) begin
            m_disp_codes = m_pend_codes;
            m_disp_dp    = m_pend_dp;
            m_flag       = 1'b0;
        end
        if (ld) begin
            m_pend_codes = c;
            m_pend_dp    = dp;
            m_flag       = 1'b1;
        end
        m_edge = e;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, codes, dp_mask);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        n_checks += 4;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h required ff", seg); end
        if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
        if (update_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b required 0", update_pending); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b required 0", frame_start); end
        repeat (2) @(negedge clk);
        sb.delete();
        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [3:0] prev_an;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                prev_an = 4'hF;
            end else begin
                if (an !== prev_an || frame_start !== 1'b0) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output cycle %0d: seg %h an %b fs %b, none required", cyc, seg, an, frame_start);
                    end else begin
                        x = sb.pop_front();
                        if (cyc != x.e || seg !== x.seg || an !== x.an || frame_start !== x.fs) begin
                            n_fail++;
                            $display("FAIL slot: got cycle %0d seg %h an %b fs %b, required cycle %0d seg %h an %b fs %b",
                                     cyc, seg, an, frame_start, x.e, x.seg, x.an, x.fs);
                        end
                    end
                end
                prev_an = an;
            end
        end
    end

    initial begin : stimulus
        model_reset();
        @(negedge clk);
        do_reset();
        idle(24);
        step(1'b1, 16'h7210, 4'h0);
        idle(24);
        idle(1);
        step(1'b1, 16'h0000, 4'h0);
        idle(2);
        step(1'b1, 16'h6666, 4'h0);
        idle(30);
        idle(8);
        step(1'b1, 16'h3333, 4'h0);
        idle(1);
        step(1'b1, 16'h4444, 4'h0);
        idle(40);
        step(1'b1, 16'hF9F5, 4'hF);
        idle(40);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 16'($urandom()), 4'($urandom_range(0, 15)));
            else
                step(1'b0, codes, dp_mask);
        end
        do_reset();
        idle(27);
        step(1'b1, 16'h1111, 4'h3);
        idle(2);
        do_reset();
        idle(40);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
